crosswalk_controller: RTL and testbench

CROSSWALK_CONTROLLER -- requirements
Module: crosswalk_controller

---
 rtl/crosswalk_controller_if.sv | 22 ++
 rtl/crosswalk_controller.sv | 125 ++++++++++++
 tb/tb_crosswalk_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/crosswalk_controller_if.sv
// Pedestrian-crossing controller bus: time base and request in, lamp and status outputs back.
interface crosswalk_controller_if;
   logic       tick;
   logic       ped_button;
   logic       car_green;
   logic       car_yellow;
   logic       car_red;
   logic       walk;
   logic       dont_walk;
   logic [7:0] countdown;
   logic       req_pending;

   modport master (
      output tick, ped_button,
      input  car_green, car_yellow, car_red, walk, dont_walk, countdown, req_pending
   );

   modport slave (
      input  tick, ped_button,
      output car_green, car_yellow, car_red, walk, dont_walk, countdown, req_pending
   );
endinterface

// File: rtl/crosswalk_controller.sv
// Six-phase crosswalk sequencer: car green/yellow, all-red, walk, flashing don't-walk, clearance.
module crosswalk_controller #(
   parameter int unsigned GREEN_MIN = 8,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 2,
   parameter int unsigned WALK_T    = 5,
   parameter int unsigned FLASH_T   = 6,
   parameter int unsigned CLEAR_T   = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   crosswalk_controller_if.slave bus
);

   typedef enum logic [2:0] {
      CAR_GREEN, CAR_YELLOW, ALL_RED, WALK, FLASH_DW, CLEAR_RED
   } state_t;

   typedef struct packed {
      logic       car_green;
      logic       car_yellow;
      logic       car_red;
      logic       walk;
      logic       dont_walk;
      logic [7:0] countdown;
   } lamps_t;

   localparam logic [7:0] GREEN_LD  = 8'(GREEN_MIN - 1);
   localparam logic [7:0] YELLOW_LD = 8'(YELLOW_T - 1);
   localparam logic [7:0] ALLRED_LD = 8'(ALLRED_T - 1);
   localparam logic [7:0] WALK_LD   = 8'(WALK_T - 1);
   localparam logic [7:0] FLASH_LD  = 8'(FLASH_T - 1);
   localparam logic [7:0] CLEAR_LD  = 8'(CLEAR_T - 1);

   function automatic state_t next_of(input state_t s);
      case (s)
         CAR_GREEN:  return CAR_YELLOW;
         CAR_YELLOW: return ALL_RED;
         ALL_RED:    return WALK;
         WALK:       return FLASH_DW;
         FLASH_DW:   return CLEAR_RED;
         default:    return CAR_GREEN;
      endcase
   endfunction

   function automatic logic [7:0] load_of(input state_t s);
      case (s)
         CAR_GREEN:  return GREEN_LD;
         CAR_YELLOW: return YELLOW_LD;
         ALL_RED:    return ALLRED_LD;
         WALK:       return WALK_LD;
         FLASH_DW:   return FLASH_LD;
         default:    return CLEAR_LD;
      endcase
   endfunction

   function automatic lamps_t decode(input state_t s, input logic ph, input logic [7:0] t);
      lamps_t l;
      l            = '0;
      l.car_green  = (s == CAR_GREEN);
      l.car_yellow = (s == CAR_YELLOW);
      l.car_red    = (s != CAR_GREEN) && (s != CAR_YELLOW);
      l.walk       = (s == WALK);
      l.dont_walk  = (s == FLASH_DW) ? ph : (s != WALK);
      l.countdown  = (s == FLASH_DW) ? t : 8'd0;
      return l;
   endfunction

   state_t     r_state, w_state_nxt;
   logic [7:0] r_timer, w_timer_nxt;
   logic       r_phase, w_phase_nxt;
   logic       r_req,   w_req_nxt;
   lamps_t     r_lamps;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_phase_nxt = r_phase;
      w_req_nxt   = r_req;

      if (bus.tick) begin
         if (r_state == FLASH_DW) w_phase_nxt = ~r_phase;
         if (r_timer != 8'd0) begin
            w_timer_nxt = r_timer - 8'd1;
         end else if (r_state != CAR_GREEN || r_req) begin
            w_state_nxt = next_of(r_state);
            w_timer_nxt = load_of(w_state_nxt);
            if (w_state_nxt == FLASH_DW) w_phase_nxt = 1'b1;
         end
      end

      // Capture is not gated by tick so a short press between ticks is never lost.
      if (bus.ped_button && r_state != WALK && r_state != FLASH_DW) w_req_nxt = 1'b1;
      // Clear is applied last so it wins over a press on the ALL_RED->WALK edge.
      if (w_state_nxt == WALK && r_state != WALK) w_req_nxt = 1'b0;
   end

   // Lamps are registered from the next-state values, so they match the state one-for-one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CAR_GREEN;
         r_timer <= GREEN_LD;
         r_phase <= 1'b1;
         r_req   <= 1'b0;
         r_lamps <= decode(CAR_GREEN, 1'b1, GREEN_LD);
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_phase <= w_phase_nxt;
         r_req   <= w_req_nxt;
         r_lamps <= decode(w_state_nxt, w_phase_nxt, w_timer_nxt);
      end
   end

   assign bus.car_green   = r_lamps.car_green;
   assign bus.car_yellow  = r_lamps.car_yellow;
   assign bus.car_red     = r_lamps.car_red;
   assign bus.walk        = r_lamps.walk;
   assign bus.dont_walk   = r_lamps.dont_walk;
   assign bus.countdown   = r_lamps.countdown;
   assign bus.req_pending = r_req;

endmodule

// File: tb/tb_crosswalk_controller.sv
// Directed bench for crosswalk_controller using parameters 4/2/1/3/5/1.
module tb_crosswalk_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   crosswalk_controller_if bus();

   crosswalk_controller #(
      .GREEN_MIN(4), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(3), .FLASH_T(5), .CLEAR_T(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       tick;
      logic       ped;
      logic [4:0] lamps;   // {green, yellow, red, walk, dont_walk}
      logic       req;
      logic [7:0] cd;
   } vec_t;

   vec_t vecs[19];

   function automatic logic [4:0] lamps();
      return {bus.car_green, bus.car_yellow, bus.car_red, bus.walk, bus.dont_walk};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input logic t, input logic p);
      bus.tick       = t;
      bus.ped_button = p;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_lamps"}, 32'(lamps()), 32'b10001);
      check({tag, "_req"},   32'(bus.req_pending), 0);
      check({tag, "_cd"},    32'(bus.countdown), 0);
   endtask

   task automatic do_reset();
      bus.tick       = 1'b0;
      bus.ped_button = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // sel: 0 = walk lamp, 1 = car green, 2 = car yellow
   task automatic run_until(input string name, input int sel, input int limit);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < limit && !hit; i++) begin
         step(1'b1, 1'b0);
         case (sel)
            0:       hit = bus.walk;
            1:       hit = bus.car_green;
            default: hit = bus.car_yellow;
         endcase
      end
      check(name, 32'(hit), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int yst, rst, wst, wend, gret, run, spans;
      logic [13:0] prev, cur;

      //                tick  ped   g y r w dw   req   cd
      vecs[0]  = '{1'b0, 1'b0, 5'b10001, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 1'b1, 5'b10001, 1'b1, 8'd0};
      vecs[2]  = '{1'b1, 1'b0, 5'b10001, 1'b1, 8'd0};
      vecs[3]  = '{1'b1, 1'b0, 5'b10001, 1'b1, 8'd0};
      vecs[4]  = '{1'b1, 1'b0, 5'b01001, 1'b1, 8'd0};
      vecs[5]  = '{1'b1, 1'b0, 5'b01001, 1'b1, 8'd0};
      vecs[6]  = '{1'b1, 1'b0, 5'b00101, 1'b1, 8'd0};
      vecs[7]  = '{1'b1, 1'b0, 5'b00110, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 1'b1, 5'b00110, 1'b0, 8'd0};
      vecs[9]  = '{1'b1, 1'b0, 5'b00110, 1'b0, 8'd0};
      vecs[10] = '{1'b1, 1'b0, 5'b00110, 1'b0, 8'd0};
      vecs[11] = '{1'b1, 1'b0, 5'b00101, 1'b0, 8'd4};
      vecs[12] = '{1'b1, 1'b0, 5'b00100, 1'b0, 8'd3};
      vecs[13] = '{1'b0, 1'b0, 5'b00100, 1'b0, 8'd3};
      vecs[14] = '{1'b1, 1'b0, 5'b00101, 1'b0, 8'd2};
      vecs[15] = '{1'b1, 1'b0, 5'b00100, 1'b0, 8'd1};
      vecs[16] = '{1'b1, 1'b0, 5'b00101, 1'b0, 8'd0};
      vecs[17] = '{1'b1, 1'b0, 5'b00101, 1'b0, 8'd0};
      vecs[18] = '{1'b1, 1'b0, 5'b10001, 1'b0, 8'd0};

      do_reset();

      // Full pedestrian cycle, one vector per clock.
      for (int i = 0; i < 19; i++) begin
         step(vecs[i].tick, vecs[i].ped);
         check($sformatf("vec%0d_lamps", i), 32'(lamps()), 32'(vecs[i].lamps));
         check($sformatf("vec%0d_req", i),   32'(bus.req_pending), 32'(vecs[i].req));
         check($sformatf("vec%0d_cd", i),    32'(bus.countdown), 32'(vecs[i].cd));
      end

      // Green holds with no request.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         check("hold_green", 32'(lamps()), 32'b10001);
         check("hold_req", 32'(bus.req_pending), 0);
      end

      // Presses during WALK are ignored.
      step(1'b1, 1'b1);
      check("req_set", 32'(bus.req_pending), 1);
      run_until("reach_walk_a", 0, 10);
      check("walk_entry_req", 32'(bus.req_pending), 0);
      step(1'b1, 1'b1);
      check("walk_press_1", 32'(bus.req_pending), 0);
      step(1'b1, 1'b1);
      check("walk_press_2", 32'(bus.req_pending), 0);
      run_until("back_to_green", 1, 20);
      check("return_req", 32'(bus.req_pending), 0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         check("green_after_walk_press", 32'(bus.car_green), 1);
      end

      // Press in CLEAR_RED latches; next green lasts exactly GREEN_MIN ticks.
      step(1'b1, 1'b1);
      run_until("reach_walk_b", 0, 10);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      check("clear_lamps", 32'(lamps()), 32'b00101);
      step(1'b1, 1'b1);
      check("clear_to_green", 32'(lamps()), 32'b10001);
      check("clear_press_req", 32'(bus.req_pending), 1);
      run = 1;
      for (int i = 0; i < 20 && !bus.car_yellow; i++) begin
         step(1'b1, 1'b0);
         if (bus.car_green) run++;
      end
      check("green_len_after_clear", 32'(run), 4);

      // Asynchronous reset in the second WALK tick.
      do_reset();
      step(1'b1, 1'b1);
      run_until("reach_walk_c", 0, 10);
      step(1'b1, 1'b0);
      check("walk_tick2", 32'(bus.walk), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_walk_reset");
      @(posedge clk);
      #1;
      check_reset_values("mid_walk_reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         check("post_reset_green", 32'(lamps()), 32'b10001);
         check("post_reset_req", 32'(bus.req_pending), 0);
      end

      // Tick every third cycle: durations scale 3x, outputs hold between ticks.
      do_reset();
      yst = -1; rst = -1; wst = -1; wend = -1; gret = -1;
      prev = {lamps(), bus.countdown, bus.req_pending};
      for (int c = 0; c < 60; c++) begin
         int e;
         logic t;
         t = (c % 3 == 0);
         e = c + 1;
         step(t, c == 0);
         cur = {lamps(), bus.countdown, bus.req_pending};
         if (!t) check("stable_between_ticks", 32'(cur), 32'(prev));
         if (bus.car_yellow && yst < 0) yst = e;
         if (bus.car_red && yst >= 0 && rst < 0) rst = e;
         if (bus.walk && wst < 0) wst = e;
         if (!bus.walk && wst >= 0 && wend < 0) wend = e;
         if (bus.car_green && wend >= 0 && gret < 0) gret = e;
         prev = cur;
      end
      check("slow_green_exit", 32'(yst), 10);
      check("slow_yellow_len", 32'(rst - yst), 6);
      check("slow_allred_len", 32'(wst - rst), 3);
      check("slow_walk_len", 32'(wend - wst), 9);
      check("slow_flash_clear_len", 32'(gret - wend), 18);

      // Button held: back-to-back cycles, lamp invariants every cycle.
      do_reset();
      run = 1;
      spans = 0;
      for (int c = 0; c < 100; c++) begin
         step(1'b1, 1'b1);
         check("onehot", 32'(int'(bus.car_green) + int'(bus.car_yellow) + int'(bus.car_red)), 1);
         check("walk_dw_excl", 32'(bus.walk & bus.dont_walk), 0);
         if (bus.car_green) begin
            run++;
         end else if (run != 0) begin
            check("held_green_len", 32'(run), 4);
            run = 0;
            spans++;
         end
      end
      check("held_span_count", 32'(spans >= 5), 1);

      // Idle: no request, green forever.
      do_reset();
      for (int c = 0; c < 100; c++) begin
         step(1'b1, 1'b0);
         check("idle_green", 32'(bus.car_green), 1);
         check("idle_dw", 32'(bus.dont_walk), 1);
         check("idle_req", 32'(bus.req_pending), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
